// File: rtl/fruit_pkg.sv
// Shared types and constants for the fruit spawner: FSM states, launch-column
// folding, angle base and LFSR feedback taps.
package fruit_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    PICK,
    LAUNCH,
    SETTLE
  } state_t;

  localparam logic [4:0]  X_FOLD_LIMIT = 5'd25;
  localparam logic [4:0]  THETA_BASE   = 5'd8;
  // Fibonacci taps 16,14,13,11 expressed as register bits 15,13,12,10
  localparam logic [15:0] LFSR_TAPS    = 16'hB400;

  // Columns above the limit fold down by 16 so the launch x stays on screen
  function automatic logic [4:0] fold_x(input logic [4:0] raw);
    return (raw > X_FOLD_LIMIT) ? raw - 5'd16 : raw;
  endfunction

endpackage

// File: rtl/fruit_spawner_if.sv
// Spawner <-> game-control / trajectory-bank signal bundle. The master side
// is the spawner; the slave side is the game logic plus trajectory units.
interface fruit_spawner_if #(
  parameter int N_SLOTS = 4
);
  logic               on;
  logic [N_SLOTS-1:0] slot_act;
  logic               coordck;
  logic [N_SLOTS-1:0] launch;
  logic [4:0]         xin;
  logic [4:0]         theta;
  logic [15:0]        spawn_cnt;
  logic               busy_all;

  modport master (
    input  on, slot_act,
    output coordck, launch, xin, theta, spawn_cnt, busy_all
  );

  modport slave (
    output on, slot_act,
    input  coordck, launch, xin, theta, spawn_cnt, busy_all
  );
endinterface

// File: rtl/spawn_lfsr.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11) stepping once per enabled cycle;
// exposes only the low bits the spawner consumes.
module spawn_lfsr
  import fruit_pkg::*;
#(
  parameter logic [15:0] SEED  = 16'hACE1,
  parameter int          OUT_W = 9
) (
  input  logic             sysck,
  input  logic             reset,
  input  logic             en,
  output logic [OUT_W-1:0] rand_bits
);

  logic [15:0] lfsr_reg;

  always_ff @(posedge sysck or posedge reset) begin
    if (reset) begin
      lfsr_reg <= SEED;
    end else if (en) begin
      lfsr_reg <= {lfsr_reg[14:0], ^(lfsr_reg & LFSR_TAPS)};
    end
  end

  assign rand_bits = lfsr_reg[OUT_W-1:0];

endmodule

// File: rtl/fruit_spawner.sv
// Fruit spawner: coordck time-base divider, spawn-interval FSM and round-robin
// launch of idle trajectory slots. Optional macro FRUIT_SPAWN_RAMP_EN shortens
// the spawn interval every 8th launch down to MIN_TICKS.
module fruit_spawner
  import fruit_pkg::*;
#(
  parameter int          N_SLOTS     = 4,
  parameter int          CK_HALF     = 25000,
  parameter int          SPAWN_TICKS = 64,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1,
  parameter int          SETTLE_CYC  = 3,
  parameter int          MIN_TICKS   = 16
) (
  input  logic             sysck,
  input  logic             reset,
  fruit_spawner_if.master  bus
);

  localparam int PTR_W    = $clog2(N_SLOTS);
  localparam int CK_W     = $clog2(CK_HALF + 1);
  localparam int SET_W    = $clog2(SETTLE_CYC + 1);
  localparam int TICK_MAX = (SPAWN_TICKS > MIN_TICKS) ? SPAWN_TICKS : MIN_TICKS;
  localparam int TICK_W   = $clog2(TICK_MAX + 1);

  state_t              state_reg;
  logic [CK_W-1:0]     div_cnt_reg;
  logic                coordck_reg;
  logic                coordck_d_reg;
  logic [TICK_W-1:0]   tick_cnt_reg;
  logic [TICK_W-1:0]   interval;
  logic [SET_W-1:0]    settle_cnt_reg;
  logic [PTR_W-1:0]    ptr_reg;
  logic [PTR_W-1:0]    slot_reg;
  logic [N_SLOTS-1:0]  launch_reg;
  logic [4:0]          xin_reg;
  logic [4:0]          theta_reg;
  logic [15:0]         spawn_cnt_reg;
  logic                busy_all_reg;
  logic [8:0]          rand_bits;
  logic                tick_rise;
  logic [N_SLOTS-1:0]  free_rot;
  logic                found;
  logic [PTR_W-1:0]    pick_off;
  logic [PTR_W-1:0]    pick_slot;
  logic [PTR_W-1:0]    next_ptr;

  function automatic logic [PTR_W-1:0] wrap_idx(input logic [PTR_W:0] a);
    return (a >= (PTR_W+1)'(N_SLOTS)) ? PTR_W'(a - (PTR_W+1)'(N_SLOTS)) : a[PTR_W-1:0];
  endfunction

  spawn_lfsr #(
    .SEED  (LFSR_SEED),
    .OUT_W (9)
  ) u_lfsr (
    .sysck     (sysck),
    .reset     (reset),
    .en        (bus.on),
    .rand_bits (rand_bits)
  );

  // Time-base divider; held quiet (and edge history cleared) while the game is off
  always_ff @(posedge sysck or posedge reset) begin
    if (reset) begin
      div_cnt_reg   <= '0;
      coordck_reg   <= 1'b0;
      coordck_d_reg <= 1'b0;
    end else if (!bus.on) begin
      div_cnt_reg   <= '0;
      coordck_reg   <= 1'b0;
      coordck_d_reg <= 1'b0;
    end else begin
      coordck_d_reg <= coordck_reg;
      if (div_cnt_reg == CK_W'(CK_HALF - 1)) begin
        div_cnt_reg <= '0;
        coordck_reg <= ~coordck_reg;
      end else begin
        div_cnt_reg <= div_cnt_reg + CK_W'(1);
      end
    end
  end

  assign tick_rise = coordck_reg & ~coordck_d_reg;

  // Free-slot map rotated so bit 0 is the round-robin pointer's slot
  genvar gi;
  generate
    for (gi = 0; gi < N_SLOTS; gi++) begin : g_rot
      assign free_rot[gi] = ~bus.slot_act[wrap_idx({1'b0, ptr_reg} + (PTR_W+1)'(gi))];
    end
  endgenerate

  always_comb begin
    found    = 1'b0;
    pick_off = '0;
    for (int i = N_SLOTS - 1; i >= 0; i--) begin
      if (free_rot[i]) begin
        found    = 1'b1;
        pick_off = PTR_W'(i);
      end
    end
  end

  assign pick_slot = wrap_idx({1'b0, ptr_reg} + {1'b0, pick_off});
  assign next_ptr  = wrap_idx({1'b0, slot_reg} + (PTR_W+1)'(1));

`ifdef FRUIT_SPAWN_RAMP_EN
  logic [TICK_W-1:0] interval_reg;

  always_ff @(posedge sysck or posedge reset) begin
    if (reset) begin
      interval_reg <= TICK_W'(SPAWN_TICKS);
    end else if (!bus.on || state_reg == IDLE) begin
      interval_reg <= TICK_W'(SPAWN_TICKS);
    end else if (state_reg == LAUNCH && spawn_cnt_reg[2:0] == 3'd7 &&
                 interval_reg > TICK_W'(MIN_TICKS)) begin
      interval_reg <= interval_reg - TICK_W'(1);
    end
  end

  assign interval = interval_reg;
`else
  assign interval = TICK_W'(SPAWN_TICKS);
`endif

  always_ff @(posedge sysck or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      tick_cnt_reg   <= '0;
      settle_cnt_reg <= '0;
      ptr_reg        <= '0;
      slot_reg       <= '0;
      launch_reg     <= '0;
      xin_reg        <= '0;
      theta_reg      <= '0;
      spawn_cnt_reg  <= '0;
      busy_all_reg   <= 1'b0;
    end else if (!bus.on) begin
      // Pointer and launch count survive a pause; everything visible goes quiet
      state_reg      <= IDLE;
      tick_cnt_reg   <= '0;
      settle_cnt_reg <= '0;
      launch_reg     <= '0;
      xin_reg        <= '0;
      theta_reg      <= '0;
      busy_all_reg   <= 1'b0;
    end else begin
      launch_reg <= '0;
      case (state_reg)
        IDLE: begin
          tick_cnt_reg <= '0;
          state_reg    <= WAIT;
        end
        WAIT: begin
          if (tick_rise) begin
            if (tick_cnt_reg + TICK_W'(1) >= interval) begin
              tick_cnt_reg <= '0;
              state_reg    <= PICK;
            end else begin
              tick_cnt_reg <= tick_cnt_reg + TICK_W'(1);
            end
          end
        end
        PICK: begin
          if (found) begin
            busy_all_reg <= 1'b0;
            slot_reg     <= pick_slot;
            launch_reg   <= {{(N_SLOTS-1){1'b0}}, 1'b1} << pick_slot;
            xin_reg      <= fold_x(rand_bits[4:0]);
            theta_reg    <= THETA_BASE + {1'b0, rand_bits[8:5]};
            state_reg    <= LAUNCH;
          end else begin
            busy_all_reg <= 1'b1;
          end
        end
        LAUNCH: begin
          // Counted on leaving LAUNCH so a pulse killed by on=0 is not counted
          spawn_cnt_reg  <= spawn_cnt_reg + 16'd1;
          ptr_reg        <= next_ptr;
          settle_cnt_reg <= '0;
          state_reg      <= SETTLE;
        end
        SETTLE: begin
          if (settle_cnt_reg == SET_W'(SETTLE_CYC - 1)) begin
            state_reg <= WAIT;
          end else begin
            settle_cnt_reg <= settle_cnt_reg + SET_W'(1);
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.coordck   = coordck_reg;
  assign bus.launch    = launch_reg & {N_SLOTS{bus.on}};
  assign bus.xin       = xin_reg;
  assign bus.theta     = theta_reg;
  assign bus.spawn_cnt = spawn_cnt_reg;
  assign bus.busy_all  = busy_all_reg;

endmodule

// File: tb/tb_fruit_spawner.sv
// Scoreboard bench for fruit_spawner: directed phases push expected launches,
// a negedge monitor pops and compares whenever a launch pulse appears.
`timescale 1ns/1ps
module tb_fruit_spawner;

  localparam int N = 4;

  logic sysck = 1'b0;
  logic reset = 1'b1;

  fruit_spawner_if #(.N_SLOTS(N)) bus ();

  fruit_spawner #(
    .N_SLOTS     (N),
    .CK_HALF     (4),
    .SPAWN_TICKS (2),
    .LFSR_SEED   (16'hACE1),
    .SETTLE_CYC  (3),
    .MIN_TICKS   (16)
  ) dut (
    .sysck (sysck),
    .reset (reset),
    .bus   (bus)
  );

  always #5 sysck = ~sysck;

  typedef struct {
    int          cyc;
    logic [3:0]  launch;
    logic [4:0]  xin;
    logic [4:0]  theta;
    logic [15:0] cnt;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;
  int   on_cyc = 0;

  // Number of enabled clock edges since reset (= LFSR steps taken)
  always @(posedge sysck or posedge reset) begin
    if (reset) on_cyc <= 0;
    else if (bus.on) on_cyc <= on_cyc + 1;
  end

  function automatic logic [15:0] lfsr_after(input int n);
    logic [15:0] v;
    v = 16'hACE1;
    for (int i = 0; i < n; i++) v = {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    return v;
  endfunction

  function automatic logic [4:0] exp_x(input int steps);
    logic [15:0] v;
    logic [4:0]  x;
    v = lfsr_after(steps);
    x = v[4:0];
    if (x > 5'd25) x = x - 5'd16;
    return x;
  endfunction

  function automatic logic [4:0] exp_theta(input int steps);
    logic [15:0] v;
    v = lfsr_after(steps);
    return 5'd8 + {1'b0, v[8:5]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic expect_launch(input int cyc, input logic [3:0] onehot, input logic [15:0] cnt);
    exp_t e;
    e.cyc    = cyc;
    e.launch = onehot;
    e.xin    = exp_x(cyc - 1);
    e.theta  = exp_theta(cyc - 1);
    e.cnt    = cnt;
    sb.push_back(e);
  endtask

  task automatic wait_cyc(input int c);
    int guard;
    guard = 0;
    while (on_cyc != c && guard < 2000) begin
      @(negedge sysck);
      guard++;
    end
    if (on_cyc != c) begin
      total++;
      bad++;
      $display("FAIL wait_cyc: got cycle %0d, expected %0d", on_cyc, c);
    end
  endtask

  always @(negedge sysck) begin
    if (bus.launch !== 4'b0000) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_launch: got launch=%b at cycle %0d, expected none", bus.launch, on_cyc);
      end else begin
        mon_e = sb.pop_front();
        check("launch_cycle", on_cyc, mon_e.cyc);
        check("launch_vec", {28'd0, bus.launch}, {28'd0, mon_e.launch});
        check("launch_xin", {27'd0, bus.xin}, {27'd0, mon_e.xin});
        check("launch_theta", {27'd0, bus.theta}, {27'd0, mon_e.theta});
        check("launch_cnt", {16'd0, bus.spawn_cnt}, {16'd0, mon_e.cnt});
        check("launch_busy", {31'd0, bus.busy_all}, 32'd0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.on       = 1'b0;
    bus.slot_act = 4'b0000;
    repeat (2) @(negedge sysck);
    check("rst_coordck", {31'd0, bus.coordck}, 32'd0);
    check("rst_launch", {28'd0, bus.launch}, 32'd0);
    check("rst_xin", {27'd0, bus.xin}, 32'd0);
    check("rst_theta", {27'd0, bus.theta}, 32'd0);
    check("rst_spawn_cnt", {16'd0, bus.spawn_cnt}, 32'd0);
    check("rst_busy", {31'd0, bus.busy_all}, 32'd0);
    reset = 1'b0;
    repeat (3) @(negedge sysck);
    check("idle_coordck", {31'd0, bus.coordck}, 32'd0);

    // First spawn: slot 0, two cycles after the 2nd coordck rise (edge 12)
    expect_launch(14, 4'b0001, 16'd0);
    bus.on = 1'b1;
    wait_cyc(15);
    check("cnt_after_first", {16'd0, bus.spawn_cnt}, 32'd1);

    // Slot 0 busy: round robin continues at slot 1
    bus.slot_act = 4'b0001;
    expect_launch(30, 4'b0010, 16'd1);
    wait_cyc(30);
    for (int k = 0; k < 3; k++) begin
      @(negedge sysck);
      check("hold_xin", {27'd0, bus.xin}, {27'd0, exp_x(29)});
      check("hold_theta", {27'd0, bus.theta}, {27'd0, exp_theta(29)});
    end

    // All slots busy: spawn pends in PICK until slot 2 frees
    bus.slot_act = 4'b1111;
    wait_cyc(45);
    check("busy_before_pick", {31'd0, bus.busy_all}, 32'd0);
    wait_cyc(46);
    check("busy_set", {31'd0, bus.busy_all}, 32'd1);
    wait_cyc(94);
    check("busy_held", {31'd0, bus.busy_all}, 32'd1);
    check("cnt_while_busy", {16'd0, bus.spawn_cnt}, 32'd2);
    bus.slot_act = 4'b1011;
    expect_launch(95, 4'b0100, 16'd2);
    wait_cyc(95);
    check("busy_cleared", {31'd0, bus.busy_all}, 32'd0);
    wait_cyc(96);
    check("cnt_after_release", {16'd0, bus.spawn_cnt}, 32'd3);

    // Drop on during the next LAUNCH cycle (edge 110, slot 2 again)
    wait_cyc(109);
    @(posedge sysck);
    #1 bus.on = 1'b0;
    #1;
    check("gated_launch", {28'd0, bus.launch}, 32'd0);
    check("gated_xin_latched", {27'd0, bus.xin}, {27'd0, exp_x(109)});
    @(negedge sysck);
    @(negedge sysck);
    check("off_coordck", {31'd0, bus.coordck}, 32'd0);
    check("off_xin", {27'd0, bus.xin}, 32'd0);
    check("off_theta", {27'd0, bus.theta}, 32'd0);
    check("off_spawn_cnt", {16'd0, bus.spawn_cnt}, 32'd3);
    check("off_launch", {28'd0, bus.launch}, 32'd0);

    // Restart, then async reset mid-WAIT while coordck is high
    bus.slot_act = 4'b0000;
    bus.on = 1'b1;
    repeat (5) @(posedge sysck);
    #1;
    check("restart_coordck", {31'd0, bus.coordck}, 32'd1);
    #1 reset = 1'b1;
    #1;
    check("async_coordck", {31'd0, bus.coordck}, 32'd0);
    check("async_spawn_cnt", {16'd0, bus.spawn_cnt}, 32'd0);
    check("async_launch", {28'd0, bus.launch}, 32'd0);
    check("async_busy", {31'd0, bus.busy_all}, 32'd0);
    expect_launch(14, 4'b0001, 16'd0);
    @(negedge sysck);
    reset = 1'b0;
    wait_cyc(15);
    check("cnt_after_reset", {16'd0, bus.spawn_cnt}, 32'd1);

    repeat (5) @(negedge sysck);
    check("sb_drained", sb.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
